vga_fb_arbiter: RTL and testbench

Shares one single-port synchronous framebuffer RAM between the VGA scan-out path and a pixel-draw writer. Sits between the VGA controller, which supplies `display_col`, `display_row` and `visible` at 800x600, and the framebuffer RAM. The framebuffer is 200x150 and is scaled 4x in both axes. Scan-out reads get fixed-slot priority, and the writer is served in every remaining slot through a valid/ready handshake.

---
 rtl/vga_pkg.sv | 27 ++
 rtl/vga_fb_addr.sv | 27 ++
 rtl/vga_fb_arbiter.sv | 164 ++++++++++++++++
 tb/tb_vga_fb_arbiter.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
`default_nettype none
// ------------------------------------------------------------------------
// vga_pkg : framebuffer geometry, scan-out depth and scheduler slot type
// Rev 1.0
// ------------------------------------------------------------------------
package vga_pkg;

    localparam int FB_W            = 200;
    localparam int FB_H            = 150;
    localparam int SCALE_LOG2      = 2;
    localparam int ADDR_W          = 15;
    localparam int SCANOUT_LATENCY = 3;

    typedef enum logic [1:0] {
        SCAN_READ   = 2'd0,
        SCAN_WRITE  = 2'd1,
        BLANK_WRITE = 2'd2
    } slot_t;

    typedef struct packed {
        logic vis;
        logic rd;
        logic border;
    } scan_flags_t;

endpackage
`default_nettype wire

// File: rtl/vga_fb_addr.sv
`default_nettype none
// ------------------------------------------------------------------------
// vga_fb_addr : framebuffer (x,y) to linear RAM address plus in-range flag
// Rev 1.0
// ------------------------------------------------------------------------
module vga_fb_addr
    import vga_pkg::*;
#(
    parameter int FB_W   = vga_pkg::FB_W,
    parameter int FB_H   = vga_pkg::FB_H,
    parameter int ADDR_W = vga_pkg::ADDR_W
) (
    input  logic [11:0]       x_i,
    input  logic [10:0]       y_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic              in_range_o
);

    localparam logic [11:0] c_FB_W = 12'(FB_W);
    localparam logic [10:0] c_FB_H = 11'(FB_H);

    // The largest in-range address fits ADDR_W, so no wrap handling is needed.
    assign addr_o     = ADDR_W'(y_i) * ADDR_W'(FB_W) + ADDR_W'(x_i);
    assign in_range_o = (x_i < c_FB_W) && (y_i < c_FB_H);

endmodule
`default_nettype wire

// File: rtl/vga_fb_arbiter.sv
`default_nettype none
// ------------------------------------------------------------------------
// vga_fb_arbiter : shares one framebuffer RAM port between scan-out and writer
// Rev 1.0
// ------------------------------------------------------------------------
module vga_fb_arbiter
    import vga_pkg::*;
#(
    parameter int                FB_W   = vga_pkg::FB_W,
    parameter int                FB_H   = vga_pkg::FB_H,
    parameter int                DATA_W = 8,
    parameter int                ADDR_W = vga_pkg::ADDR_W,
    parameter logic [DATA_W-1:0] BORDER = '0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [11:0]       display_col,
    input  logic [10:0]       display_row,
    input  logic              visible,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [11:0]       wr_x,
    input  logic [10:0]       wr_y,
    input  logic [DATA_W-1:0] wr_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] pixel_data,
    output logic              pixel_valid,
    output logic [15:0]       drop_count
);

    localparam int c_STAGES = SCANOUT_LATENCY - 1;

    logic [11:0]       scan_x;
    logic [10:0]       scan_y;
    logic [ADDR_W-1:0] scan_addr;
    logic              scan_in_range;
    logic [ADDR_W-1:0] wr_addr;
    logic              wr_in_range;
    logic              wr_accept;
    slot_t             slot;

    logic [ADDR_W-1:0] mem_addr_q,    mem_addr_d;
    logic              mem_we_q,      mem_we_d;
    logic [DATA_W-1:0] mem_wdata_q,   mem_wdata_d;
    logic [15:0]       drop_count_q,  drop_count_d;
    logic [DATA_W-1:0] pixel_data_q,  pixel_data_d;
    logic              pixel_valid_q, pixel_valid_d;
    scan_flags_t       flags_d;
    scan_flags_t       flags_q [c_STAGES];

    assign scan_x = display_col >> SCALE_LOG2;
    assign scan_y = display_row >> SCALE_LOG2;

    vga_fb_addr #(
        .FB_W   (FB_W),
        .FB_H   (FB_H),
        .ADDR_W (ADDR_W)
    ) u_scan_addr (
        .x_i        (scan_x),
        .y_i        (scan_y),
        .addr_o     (scan_addr),
        .in_range_o (scan_in_range)
    );

    vga_fb_addr #(
        .FB_W   (FB_W),
        .FB_H   (FB_H),
        .ADDR_W (ADDR_W)
    ) u_wr_addr (
        .x_i        (wr_x),
        .y_i        (wr_y),
        .addr_o     (wr_addr),
        .in_range_o (wr_in_range)
    );

    // Only the first column of each 4-column group needs a fresh fetch.
    always_comb begin
        slot = BLANK_WRITE;
        if (visible) begin
            if ((display_col[SCALE_LOG2-1:0] == '0) && scan_in_range) begin
                slot = SCAN_READ;
            end else begin
                slot = SCAN_WRITE;
            end
        end
    end

    assign wr_ready  = !reset && (slot != SCAN_READ);
    assign wr_accept = wr_valid && wr_ready;

    always_comb begin
        mem_addr_d   = mem_addr_q;
        mem_we_d     = 1'b0;
        mem_wdata_d  = mem_wdata_q;
        drop_count_d = drop_count_q;
        if (slot == SCAN_READ) begin
            mem_addr_d = scan_addr;
        end else if (wr_accept) begin
            if (wr_in_range) begin
                mem_addr_d  = wr_addr;
                mem_we_d    = 1'b1;
                mem_wdata_d = wr_data;
            end else if (drop_count_q != 16'hFFFF) begin
                drop_count_d = drop_count_q + 16'd1;
            end
        end
    end

    always_comb begin
        flags_d.vis    = visible;
        flags_d.rd     = (slot == SCAN_READ);
        flags_d.border = visible && !scan_in_range;
    end

    // The last flag stage lines up with mem_rdata for the matching read slot.
    always_comb begin
        pixel_valid_d = flags_q[c_STAGES-1].vis;
        pixel_data_d  = pixel_data_q;
        if (!flags_q[c_STAGES-1].vis) begin
            pixel_data_d = '0;
        end else if (flags_q[c_STAGES-1].rd) begin
            pixel_data_d = mem_rdata;
        end else if (flags_q[c_STAGES-1].border) begin
            pixel_data_d = BORDER;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            mem_addr_q    <= '0;
            mem_we_q      <= 1'b0;
            mem_wdata_q   <= '0;
            drop_count_q  <= '0;
            pixel_data_q  <= '0;
            pixel_valid_q <= 1'b0;
            for (int i = 0; i < c_STAGES; i++) begin
                flags_q[i] <= '0;
            end
        end else begin
            mem_addr_q    <= mem_addr_d;
            mem_we_q      <= mem_we_d;
            mem_wdata_q   <= mem_wdata_d;
            drop_count_q  <= drop_count_d;
            pixel_data_q  <= pixel_data_d;
            pixel_valid_q <= pixel_valid_d;
            flags_q[0]    <= flags_d;
            for (int i = 1; i < c_STAGES; i++) begin
                flags_q[i] <= flags_q[i-1];
            end
        end
    end

    assign mem_addr    = mem_addr_q;
    assign mem_we      = mem_we_q;
    assign mem_wdata   = mem_wdata_q;
    assign drop_count  = drop_count_q;
    assign pixel_data  = pixel_data_q;
    assign pixel_valid = pixel_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_fb_arbiter.sv
`default_nettype none
// ------------------------------------------------------------------------
// tb_vga_fb_arbiter : scoreboard bench for vga_fb_arbiter with a RAM model
// Rev 1.0
// ------------------------------------------------------------------------
module tb_vga_fb_arbiter;

    localparam int         FBW        = 200;
    localparam int         FBH        = 150;
    localparam logic [7:0] BORDER_VAL = 8'hA5;

    typedef struct {
        int          due;
        logic        we;
        logic [14:0] addr;
        logic [7:0]  wdata;
        bit          chk_wd;
        logic [15:0] drop;
    } mem_exp_t;

    typedef struct {
        int         due;
        logic [7:0] data;
        logic       valid;
        bit         chk_data;
    } pix_exp_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [11:0] display_col = '0;
    logic [10:0] display_row = '0;
    logic        visible = 1'b0;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [11:0] wr_x = '0;
    logic [10:0] wr_y = '0;
    logic [7:0]  wr_data = '0;
    logic [14:0] mem_addr;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata = '0;
    logic [7:0]  pixel_data;
    logic        pixel_valid;
    logic [15:0] drop_count;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    mem_exp_t mem_q[$];
    pix_exp_t pix_q[$];
    bit       rdy_q[$];

    // Reference state: framebuffer contents and the observable registers.
    logic [7:0]  mfb [0:29999];
    logic [7:0]  ram [0:32767];
    logic [14:0] m_last_addr = '0;
    logic [15:0] m_drop = '0;
    logic [7:0]  held = '0;
    bit          held_known = 1'b0;

    vga_fb_arbiter #(
        .FB_W   (FBW),
        .FB_H   (FBH),
        .DATA_W (8),
        .ADDR_W (15),
        .BORDER (BORDER_VAL)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .display_col (display_col),
        .display_row (display_row),
        .visible     (visible),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_x        (wr_x),
        .wr_y        (wr_y),
        .wr_data     (wr_data),
        .mem_addr    (mem_addr),
        .mem_we      (mem_we),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .pixel_data  (pixel_data),
        .pixel_valid (pixel_valid),
        .drop_count  (drop_count)
    );

    always #5 clock = ~clock;

    // Single-port synchronous RAM, read-first, one cycle read latency.
    always @(posedge clock) begin
        if (mem_we === 1'b1) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    initial forever begin
        @(posedge clock);
        cyc++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor for the combinational handshake, sampled mid-cycle.
    initial forever begin
        @(negedge clock);
        #3;
        if (rdy_q.size() > 0) begin
            bit r;
            r = rdy_q.pop_front();
            check("wr_ready", {31'd0, wr_ready}, {31'd0, r});
        end
    end

    // Monitor for registered outputs, sampled just after the active edge.
    initial forever begin
        @(posedge clock);
        #1;
        while (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            mem_exp_t e;
            e = mem_q.pop_front();
            check("mem_sched", e.due, cyc);
            check("mem_we", {31'd0, mem_we}, {31'd0, e.we});
            check("mem_addr", {17'd0, mem_addr}, {17'd0, e.addr});
            if (e.chk_wd) check("mem_wdata", {24'd0, mem_wdata}, {24'd0, e.wdata});
            check("drop_count", {16'd0, drop_count}, {16'd0, e.drop});
        end
        while (pix_q.size() > 0 && pix_q[0].due <= cyc) begin
            pix_exp_t p;
            p = pix_q.pop_front();
            check("pix_sched", p.due, cyc);
            check("pixel_valid", {31'd0, pixel_valid}, {31'd0, p.valid});
            if (p.chk_data) check("pixel_data", {24'd0, pixel_data}, {24'd0, p.data});
        end
    end

    task automatic step(input bit rst, input bit vis, input int col, input int row,
                        input bit wv, input int wx, input int wy, input logic [7:0] wd);
        int       fx, fy;
        bit       inr, rd, rdy, acc;
        mem_exp_t me;
        pix_exp_t pe;
        @(negedge clock);
        reset       = rst;
        visible     = vis;
        display_col = 12'(col);
        display_row = 11'(row);
        wr_valid    = wv;
        wr_x        = 12'(wx);
        wr_y        = 11'(wy);
        wr_data     = wd;
        fx  = col / 4;
        fy  = row / 4;
        inr = (fx < FBW) && (fy < FBH);
        rd  = vis && (col % 4 == 0) && inr;
        rdy = !rst && !rd;
        acc = wv && rdy;
        rdy_q.push_back(rdy);
        if (rst) begin
            m_last_addr = '0;
            m_drop      = '0;
            held_known  = 1'b0;
            me = '{due: cyc + 1, we: 1'b0, addr: 15'd0, wdata: 8'd0, chk_wd: 1'b1, drop: 16'd0};
            while (pix_q.size() > 0 && pix_q[pix_q.size()-1].due > cyc) void'(pix_q.pop_back());
            for (int i = 1; i <= 3; i++) begin
                pix_q.push_back('{due: cyc + i, data: 8'd0, valid: 1'b0, chk_data: 1'b1});
            end
        end else begin
            me = '{due: cyc + 1, we: 1'b0, addr: m_last_addr, wdata: 8'd0, chk_wd: 1'b0, drop: 16'd0};
            if (rd) begin
                m_last_addr = 15'(fy * FBW + fx);
                me.addr     = m_last_addr;
            end else if (acc) begin
                if (wx < FBW && wy < FBH) begin
                    m_last_addr         = 15'(wy * FBW + wx);
                    mfb[wy * FBW + wx]  = wd;
                    me.we               = 1'b1;
                    me.addr             = m_last_addr;
                    me.wdata            = wd;
                    me.chk_wd           = 1'b1;
                end else if (m_drop != 16'hFFFF) begin
                    m_drop = m_drop + 16'd1;
                end
            end
            me.drop = m_drop;
            if (!vis) begin
                held_known = 1'b0;
                pe = '{due: cyc + 3, data: 8'd0, valid: 1'b0, chk_data: 1'b1};
            end else begin
                if (rd) begin
                    held       = mfb[fy * FBW + fx];
                    held_known = 1'b1;
                end else if (!inr) begin
                    held       = BORDER_VAL;
                    held_known = 1'b1;
                end
                pe = '{due: cyc + 3, data: held, valid: 1'b1, chk_data: held_known};
            end
            pix_q.push_back(pe);
        end
        mem_q.push_back(me);
    endtask

    task automatic preload_drop(input logic [15:0] v);
        @(posedge clock);
        #2;
        force dut.drop_count_q = v;
        #1;
        release dut.drop_count_q;
        m_drop = v;
    endtask

    initial begin
        for (int i = 0; i < 30000; i++) mfb[i] = 8'd0;
        for (int i = 0; i < 32768; i++) ram[i] = 8'd0;

        // Reset at the first visible position, with a write attempt that must be refused.
        step(1, 1, 0, 0, 1, 5, 5, 8'h11);
        step(1, 1, 0, 0, 1, 5, 5, 8'h11);
        step(0, 1, 0, 0, 0, 0, 0, 8'h00);
        step(0, 1, 1, 0, 0, 0, 0, 8'h00);

        // Seed (3,2) and scan it out at row 8, cols 12..19.
        step(0, 0, 0, 0, 1, 3, 2, 8'h5A);
        for (int c = 12; c < 20; c++) step(0, 1, c, 8, 0, 0, 0, 8'h00);

        // Writer held valid across a visible group pair: only read slots stall it.
        for (int c = 0; c < 7; c++) step(0, 1, c, 0, 1, c * 10, c, 8'(8'h40 + c));
        step(0, 1, 7, 0, 1, 199, 149, 8'h3C);
        for (int c = 0; c < 8; c++) step(0, 1, c, 0, 0, 0, 0, 8'h00);

        // Out-of-range writes are dropped and counted, then the counter saturates.
        step(0, 0, 0, 0, 1, 200, 0, 8'hEE);
        step(0, 0, 0, 0, 1, 0, 150, 8'hEE);
        preload_drop(16'hFFFD);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1, 250, 3, 8'hEE);

        // Blanking: every cycle is a write slot.
        for (int i = 0; i < 100; i++) begin
            step(0, 0, 900, 620, 1, int'($urandom_range(0, FBW - 1)),
                 int'($urandom_range(0, FBH - 1)), 8'($urandom));
        end

        // Reset right after a handshake: the pending RAM write still lands.
        step(0, 0, 0, 0, 1, 10, 10, 8'h77);
        step(1, 1, 40, 40, 1, 10, 11, 8'h99);
        for (int c = 40; c < 44; c++) step(0, 1, c, 40, 0, 0, 0, 8'h00);
        step(0, 1, 40, 44, 0, 0, 0, 8'h00);

        // Randomised bursts with display jumps, border regions and occasional reset.
        for (int b = 0; b < 40; b++) begin
            int  col, row, len;
            bit  vis;
            col = int'($urandom_range(0, 1055));
            row = int'($urandom_range(0, 627));
            len = int'($urandom_range(4, 16));
            vis = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 29) == 0) step(1, vis, col, row, 1, 1, 1, 8'h01);
            for (int k = 0; k < len; k++) begin
                step(0, vis, col + k, row, bit'($urandom_range(0, 1)),
                     int'($urandom_range(0, 219)), int'($urandom_range(0, 164)), 8'($urandom));
            end
        end

        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 0, 0, 8'h00);
        for (int i = 0; i < 20 && (mem_q.size() > 0 || pix_q.size() > 0); i++) @(posedge clock);
        #2;
        check("drain_mem", mem_q.size(), 0);
        check("drain_pix", pix_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
